// File: rtl/fact_pkg.sv
// Shared constants, FSM state type and factorial reference table for the
// iterative factorial encode/decode units.
package fact_pkg;

  localparam int FACT_MAX_N = 12;
  localparam int PROD_W     = 36;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } fact_inv_state_t;

  // 1!..12!, indexed by n; used by reference models
  localparam logic [31:0] FACT_TBL [1:12] = '{
    32'd1,       32'd2,        32'd6,         32'd24,
    32'd120,     32'd720,      32'd5040,      32'd40320,
    32'd362880,  32'd3628800,  32'd39916800,  32'd479001600
  };

endpackage

// File: rtl/fact_inverse.sv
// Iterative inverse factorial: largest n in 1..FACT_MAX_N with n! <= i_data.
// Optional remainder output (i_data - n!) enabled by defining FACT_INV_REM_EN.
module fact_inverse
  import fact_pkg::*;
#(
  parameter int FACT_MAX_N = fact_pkg::FACT_MAX_N,
  parameter int PROD_W     = fact_pkg::PROD_W
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_data,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [3:0]  o_n,
  output logic        o_exact,
`ifdef FACT_INV_REM_EN
  output logic        o_err,
  output logic [31:0] o_rem
`else
  output logic        o_err
`endif
);

  localparam logic [3:0] MAX_K = 4'(FACT_MAX_N);

  fact_inv_state_t r_state;
  fact_inv_state_t w_state_next;

  logic [31:0]       r_val;
  logic [PROD_W-1:0] r_prod;
  logic [3:0]        r_k;
  logic              r_ready;
  logic              r_valid;
  logic [3:0]        r_n;
  logic              r_exact;
  logic              r_err;

  logic [3:0]        w_k_inc;
  logic [PROD_W-1:0] w_next;
  logic [PROD_W-1:0] w_val_ext;
  logic              w_accept;
  logic              w_step;
  logic              w_zero;

  assign w_accept  = (r_state == IDLE) && r_ready && i_valid;
  assign w_zero    = (r_val == 32'd0);
  assign w_val_ext = {{(PROD_W-32){1'b0}}, r_val};

  // r_k never exceeds FACT_MAX_N, so r_k+1 fits in 4 bits and the
  // PROD_W-wide product of r_prod and a 4-bit factor cannot truncate.
  always_comb begin
    w_k_inc = r_k + 4'd1;
    w_next  = r_prod * {{(PROD_W-4){1'b0}}, w_k_inc};
  end

  always_comb begin
    w_state_next = r_state;
    w_step       = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_state_next = SCAN;
      end
      SCAN: begin
        if (w_zero) begin
          w_state_next = DONE;
        end else if ((r_k < MAX_K) && (w_next <= w_val_ext)) begin
          w_step = 1'b1;
        end else begin
          w_state_next = DONE;
        end
      end
      DONE: begin
        if (i_ready) w_state_next = IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

`ifdef FACT_INV_REM_EN
  logic [31:0] r_rem;
`endif

  // o_ready is registered so it stays low during reset and rises on the
  // first edge after release, and on the edge that releases a result.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_val   <= 32'd0;
      r_prod  <= '0;
      r_k     <= 4'd0;
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_n     <= 4'd0;
      r_exact <= 1'b0;
      r_err   <= 1'b0;
`ifdef FACT_INV_REM_EN
      r_rem   <= 32'd0;
`endif
    end else begin
      r_ready <= (w_state_next == IDLE);
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_val  <= i_data;
            r_prod <= {{(PROD_W-1){1'b0}}, 1'b1};
            r_k    <= 4'd1;
          end
        end
        SCAN: begin
          if (w_zero) begin
            r_valid <= 1'b1;
            r_n     <= 4'd0;
            r_exact <= 1'b0;
            r_err   <= 1'b1;
`ifdef FACT_INV_REM_EN
            r_rem   <= 32'd0;
`endif
          end else if (w_step) begin
            r_prod <= w_next;
            r_k    <= w_k_inc;
          end else begin
            r_valid <= 1'b1;
            r_n     <= r_k;
            r_exact <= (r_prod == w_val_ext);
            r_err   <= 1'b0;
`ifdef FACT_INV_REM_EN
            r_rem   <= r_val - r_prod[31:0];
`endif
          end
        end
        DONE: begin
          if (i_ready) r_valid <= 1'b0;
        end
        default: r_valid <= 1'b0;
      endcase
    end
  end

  assign o_ready = r_ready;
  assign o_valid = r_valid;
  assign o_n     = r_n;
  assign o_exact = r_exact;
  assign o_err   = r_err;
`ifdef FACT_INV_REM_EN
  assign o_rem   = r_rem;
`endif

endmodule

// File: tb/tb_fact_inverse.sv
// Directed bench for fact_inverse with a table-driven reference model and a
// per-cycle output compare process; define FACT_INV_REM_EN to check o_rem.
module tb_fact_inverse;
  import fact_pkg::*;

  logic        clk;
  logic        rstn;
  logic        i_valid;
  logic        o_ready;
  logic [31:0] i_data;
  logic        o_valid;
  logic        i_ready;
  logic [3:0]  o_n;
  logic        o_exact;
  logic        o_err;
`ifdef FACT_INV_REM_EN
  logic [31:0] o_rem;
`endif

  fact_inverse dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_data  (i_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_n     (o_n),
    .o_exact (o_exact),
`ifdef FACT_INV_REM_EN
    .o_err   (o_err),
    .o_rem   (o_rem)
`else
    .o_err   (o_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Reference model: scan the factorial table for the largest n! <= v.
  function automatic void model(input logic [31:0] v, output int n, output bit exact,
                                output bit err, output logic [31:0] rem);
    n = 0;
    for (int k = 1; k <= 12; k++)
      if (FACT_TBL[k] <= v) n = k;
    err   = (v == 32'd0);
    exact = 1'b0;
    rem   = 32'd0;
    if (!err) begin
      exact = (FACT_TBL[n] == v);
      rem   = v - FACT_TBL[n];
    end
  endfunction

  bit          exp_active = 1'b0;
  int          exp_n;
  bit          exp_exact;
  bit          exp_err;
  logic [31:0] exp_rem;

  // Compare process: every cycle a result is presented it must match the model.
  always @(negedge clk) begin
    if (rstn && o_valid) begin
      if (!exp_active) begin
        check("unexpected_valid", 64'(o_valid), 64'd0);
      end else begin
        check("cyc_n", 64'(o_n), 64'(exp_n));
        check("cyc_exact", 64'(o_exact), 64'(exp_exact));
        check("cyc_err", 64'(o_err), 64'(exp_err));
`ifdef FACT_INV_REM_EN
        check("cyc_rem", 64'(o_rem), 64'(exp_rem));
`endif
      end
    end
  end

  typedef struct {
    logic [31:0] v;
    int          stall;
    bit          noisy;
    int          n;
    bit          ex;
    bit          err;
    logic [31:0] rem;
    int          lat;
  } vec_t;

  vec_t vecs [10];

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (o_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", 64'(o_ready), 64'd1);
  endtask

  // Accept v on the next ready edge; leaves the bench just after that edge.
  task automatic accept(input logic [31:0] v, output bit ok);
    wait_ready(ok);
    if (ok) begin
      model(v, exp_n, exp_exact, exp_err, exp_rem);
      exp_active = 1'b1;
      i_valid = 1'b1;
      i_data  = v;
      @(posedge clk);
      #1;
      i_valid = 1'b0;
      check("ready_low_after_accept", 64'(o_ready), 64'd0);
    end
  endtask

  task automatic run(input vec_t tv);
    bit ok;
    int lat;
    accept(tv.v, ok);
    if (ok) begin
      if (tv.noisy) begin
        i_valid = 1'b1;
        i_data  = 32'h0000_0018;
      end
      lat = 0;
      for (int c = 0; c < 20; c++) begin
        @(posedge clk);
        #1;
        lat++;
        if (o_valid) break;
      end
      check("latency", 64'(lat), 64'(tv.lat));
      check("lit_n", 64'(o_n), 64'(tv.n));
      check("lit_exact", 64'(o_exact), 64'(tv.ex));
      check("lit_err", 64'(o_err), 64'(tv.err));
`ifdef FACT_INV_REM_EN
      check("lit_rem", 64'(o_rem), 64'(tv.rem));
`endif
      for (int s = 0; s < tv.stall; s++) begin
        @(posedge clk);
        #1;
        check("stall_valid_held", 64'(o_valid), 64'd1);
        check("stall_ready_low", 64'(o_ready), 64'd0);
      end
      i_valid = 1'b0;
      i_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_active = 1'b0;
      i_ready = 1'b0;
      check("valid_cleared", 64'(o_valid), 64'd0);
      check("ready_after_release", 64'(o_ready), 64'd1);
      $display("txn v=%0d n=%0d exact=%0d err=%0d latency=%0d", tv.v, o_n, o_exact, o_err, lat);
    end
  endtask

  initial begin
    bit ok;
    vecs[0] = '{32'd479001600,  0, 1'b0, 12, 1'b1, 1'b0, 32'd0,          12};
    vecs[1] = '{32'd5,          0, 1'b1,  2, 1'b0, 1'b0, 32'd3,           2};
    vecs[2] = '{32'd0,          0, 1'b0,  0, 1'b0, 1'b1, 32'd0,           1};
    vecs[3] = '{32'hFFFF_FFFF,  0, 1'b0, 12, 1'b0, 1'b0, 32'd3815965695, 12};
    vecs[4] = '{32'd1,          5, 1'b1,  1, 1'b1, 1'b0, 32'd0,           1};
    vecs[5] = '{32'd6,          0, 1'b0,  3, 1'b1, 1'b0, 32'd0,           3};
    vecs[6] = '{32'd7,          1, 1'b1,  3, 1'b0, 1'b0, 32'd1,           3};
    vecs[7] = '{32'd3628799,    0, 1'b0,  9, 1'b0, 1'b0, 32'd3265919,     9};
    vecs[8] = '{32'd40320,      0, 1'b0,  8, 1'b1, 1'b0, 32'd0,           8};
    vecs[9] = '{32'd2,          2, 1'b0,  2, 1'b1, 1'b0, 32'd0,           2};

    i_valid = 1'b0;
    i_ready = 1'b0;
    i_data  = 32'd0;
    rstn    = 1'b1;
    #1 rstn = 1'b0;
    #2;
    check("rst_ready", 64'(o_ready), 64'd0);
    check("rst_valid", 64'(o_valid), 64'd0);
    check("rst_n", 64'(o_n), 64'd0);
    check("rst_exact", 64'(o_exact), 64'd0);
    check("rst_err", 64'(o_err), 64'd0);
`ifdef FACT_INV_REM_EN
    check("rst_rem", 64'(o_rem), 64'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_ready_held", 64'(o_ready), 64'd0);
    rstn = 1'b1;
    @(posedge clk);
    #1;
    check("ready_after_reset", 64'(o_ready), 64'd1);

    foreach (vecs[i]) run(vecs[i]);

    // Asynchronous reset in the middle of a scan discards the result.
    accept(32'd720, ok);
    if (ok) begin
      for (int c = 0; c < 3; c++) begin
        @(posedge clk);
        #1;
      end
      check("scan_no_valid", 64'(o_valid), 64'd0);
      #2 rstn = 1'b0;
      #1;
      exp_active = 1'b0;
      check("midscan_rst_ready", 64'(o_ready), 64'd0);
      check("midscan_rst_valid", 64'(o_valid), 64'd0);
      check("midscan_rst_n", 64'(o_n), 64'd0);
      check("midscan_rst_exact", 64'(o_exact), 64'd0);
      @(negedge clk);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_midscan_rst", 64'(o_ready), 64'd1);
      $display("txn v=720 aborted by reset");
    end
    run('{32'd24, 0, 1'b0, 4, 1'b1, 1'b0, 32'd0, 4});

    // Reset while a result is held in DONE.
    accept(32'd120, ok);
    if (ok) begin
      for (int c = 0; c < 7; c++) begin
        @(posedge clk);
        #1;
      end
      check("done_valid_before_rst", 64'(o_valid), 64'd1);
      rstn = 1'b0;
      #1;
      exp_active = 1'b0;
      check("done_rst_valid", 64'(o_valid), 64'd0);
      check("done_rst_n", 64'(o_n), 64'd0);
      @(negedge clk);
      rstn = 1'b1;
      @(posedge clk);
      #1;
      check("ready_after_done_rst", 64'(o_ready), 64'd1);
      $display("txn v=120 aborted by reset in DONE");
    end

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fact_inverse.md
# fact_inverse

Iterative inverse-factorial unit: accepts a 32-bit value and returns the largest n in 1..12 with n! <= value, plus an exactness flag. It is the decode counterpart of the team's iterative factorial generator. It sits on the same datapath and checks or decodes factorial-coded words produced upstream. Both sides use a valid/ready handshake, and one value is processed at a time.

## Interface
- FACT_MAX_N, default 12: largest n searched; 12! is the largest factorial that fits in 32 bits.
- PROD_W, default 36: width of the internal product register; must hold FACT_MAX_N! * (FACT_MAX_N+1).
- clk  in  1  clock.
- rstn  in  1  reset, asynchronous, active-low.
- i_valid  in  1  input value present.
- o_ready  out  1  unit can accept a value; high only in IDLE.
- i_data  in  32  value to decode.
- o_valid  out  1  result present; held until consumed.
- i_ready  in  1  downstream accepts the result.
- o_n  out  4  decoded n, in 0..12.
- o_exact  out  1  high when o_n! == the input value.
- o_err  out  1  input was 0; no n exists.
- o_rem  out  32  input value minus o_n!; present only with FACT_INV_REM_EN.

## Operation
- States are IDLE, SCAN and DONE.
- IDLE:
  - o_ready=1.
  - On i_valid&&o_ready, load r_val=i_data, r_prod=1, r_k=1, and go to SCAN.
- SCAN, one step per cycle:
  - Compute next = r_prod*(r_k+1) at PROD_W bits. The multiply is 36x4 and must never truncate.
  - If r_val==0: go to DONE with o_err=1, o_n=0, o_exact=0.
  - Else if r_k<FACT_MAX_N and next<=r_val: r_prod<=next, r_k<=r_k+1.
  - Else: go to DONE with o_n=r_k and o_exact=(r_prod==r_val).
- DONE:
  - o_valid=1; o_n, o_exact, o_err and o_rem are stable.
  - On i_ready, go to IDLE and clear o_valid.
- All comparisons are unsigned. r_val is zero-extended to PROD_W.
- Value 1 decodes to n=1 exact; 0! is never reported.
- i_data and i_valid are ignored outside IDLE. No input is buffered.

## Timing
- Reset values: o_ready=0 while rstn is low, then 1 (IDLE) on the first cycle after release. o_valid=0, o_n=0, o_exact=0, o_err=0, o_rem=0. Internal registers are 0.
- Latency: for result n, o_valid rises n clock edges after the accepting edge. A zero input has latency 1. The worst case is 12 cycles.
- o_ready falls on the edge after acceptance. After the output handshake edge, o_ready is 1 on the next cycle. The same edge never both releases a result and accepts a new value.
- Throughput: one value per n+2 cycles when i_ready is held high.
- o_valid may not drop, and outputs may not change, until i_ready is seen high.
- The rstn assertion is asynchronous at any state, including mid-SCAN and DONE with o_valid high. It returns to the reset values immediately, and the in-flight result is discarded.

## Configuration
- FACT_INV_REM_EN is defined:
  - The o_rem port exists.
  - In DONE, o_rem = r_val - r_prod[31:0].
  - o_rem = 0 when o_err=1.
- FACT_INV_REM_EN is undefined:
  - The o_rem port and its subtractor are absent.
  - All other behaviour and timing are identical.

## Structure
- Shared package fact_pkg contains:
  - FACT_MAX_N.
  - PROD_W.
  - The state enum typedef fact_inv_state_t (IDLE, SCAN, DONE).
  - A localparam array of 32-bit factorials 1!..12!, for bench reference models.
- No sub-module. The single multiply-compare step stays inline in the one FSM/datapath always_ff plus a small combinational next-product block.

## Test plan
- i_data=479001600 (12!) -> o_n=12, o_exact=1, o_err=0, o_rem=0; o_valid 12 cycles after accept.
- i_data=5 -> o_n=2, o_exact=0, o_rem=3; latency 2.
- i_data=0 -> o_err=1, o_n=0, o_exact=0; latency 1.
- i_data=32'hFFFF_FFFF -> o_n=12, o_exact=0, o_rem=3815965695; the internal product reaches 13! without truncation and does not overflow.
- i_data=1, with i_ready held low for 5 cycles:
  - Expect o_n=1 and o_exact=1, held stable while o_valid stays high.
  - o_ready stays low during the stall.
  - i_valid pulses during SCAN/DONE are ignored.
  - o_ready returns high one cycle after i_ready.
- Accept 720 (6!), then drop rstn after 3 SCAN cycles: outputs go to reset values immediately. After release, 24 is decoded as o_n=4, o_exact=1.
